// File: rtl/pic_host_initiator.sv
// pic_host_initiator: CPU-side bus initiator for the 8259 PIC.
// Runs ICW1..ICW4 + OCW1 initialisation, forwards OCW writes from a
// command port and services INT with an 8086-style two-pulse acknowledge,
// capturing the vector byte supplied during the second pulse.
// Optional build macro: PIC_HOST_INT_SYNC_EN adds a 2-flop synchronizer
// on INT (two extra cycles of INT-to-int_ack latency).
module pic_host_initiator #(
    parameter logic [7:0] ICW1      = 8'h13,
    parameter logic [7:0] ICW2      = 8'h20,
    parameter logic [7:0] ICW3      = 8'h00,
    parameter logic [7:0] ICW4      = 8'h01,
    parameter logic [7:0] OCW1_INIT = 8'hFF,
    parameter int         WR_WIDTH  = 2,
    parameter int         ACK_WIDTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_init,
    output logic       init_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    input  logic       INT,
    output logic       int_ack,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       a0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in,
    output logic [7:0] vector,
    output logic       vector_valid
);

    typedef enum logic [2:0] {
        IDLE, WR_LOW, WR_REC, ACK1, ACK_GAP, ACK2, ACK_DONE, HOLDOFF
    } state_t;

    // Last count value of each timed phase (counters start at 0).
    localparam logic [7:0] WR_LAST  = 8'(WR_WIDTH - 1);
    localparam logic [7:0] ACK_LAST = 8'(ACK_WIDTH - 1);

    // Init step indices: 0 ICW1, 1 ICW2, 2 ICW3, 3 ICW4, 4 OCW1_INIT.
    localparam logic [2:0] STEP_LAST = 3'd4;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] step_q, step_d;
    logic       init_mode_q, init_mode_d;
    logic       init_done_q, init_done_d;
    logic       a0_q, a0_d;
    logic [7:0] data_q, data_d;
    logic [7:0] vector_q, vector_d;
    logic       int_s;

    // Step that follows s, skipping ICW3 in single mode and ICW4 when not requested.
    function automatic logic [2:0] next_step(input logic [2:0] s);
        logic [2:0] n;
        case (s)
            3'd0:    n = 3'd1;
            3'd1:    n = (ICW1[1] == 1'b0) ? 3'd2 : (ICW1[0] ? 3'd3 : 3'd4);
            3'd2:    n = ICW1[0] ? 3'd3 : 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Byte written for a given init step.
    function automatic logic [7:0] step_byte(input logic [2:0] s);
        logic [7:0] b;
        case (s)
            3'd0:    b = ICW1;
            3'd1:    b = ICW2;
            3'd2:    b = ICW3;
            3'd3:    b = ICW4;
            default: b = OCW1_INIT;
        endcase
        return b;
    endfunction

`ifdef PIC_HOST_INT_SYNC_EN
    logic [1:0] int_sync_q;

    // Two-flop synchronizer for an INT coming from another clock domain.
    always_ff @(posedge clk) begin
        if (reset) int_sync_q <= 2'b00;
        else       int_sync_q <= {int_sync_q[0], INT};
    end

    assign int_s = int_sync_q[1];
`else
    assign int_s = INT;
`endif

    // State and datapath registers; reset returns every output to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            step_q      <= 3'd0;
            init_mode_q <= 1'b0;
            init_done_q <= 1'b0;
            a0_q        <= 1'b0;
            data_q      <= 8'd0;
            vector_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            init_mode_q <= init_mode_d;
            init_done_q <= init_done_d;
            a0_q        <= a0_d;
            data_q      <= data_d;
            vector_q    <= vector_d;
        end
    end

    // Next-state logic: IDLE arbitration, write timing, init stepping, ack sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        init_mode_d = init_mode_q;
        init_done_d = init_done_q;
        a0_d        = a0_q;
        data_d      = data_q;
        vector_d    = vector_q;
        cmd_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_init) begin
                    init_done_d = 1'b0;
                    init_mode_d = 1'b1;
                    step_d      = 3'd0;
                    a0_d        = 1'b0;
                    data_d      = ICW1;
                    cnt_d       = 8'd0;
                    state_d     = WR_LOW;
                end else if (init_done_q && int_s) begin
                    cnt_d   = 8'd0;
                    state_d = ACK1;
                end else if (init_done_q) begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) begin
                        init_mode_d = 1'b0;
                        a0_d        = cmd_a0;
                        data_d      = cmd_data;
                        cnt_d       = 8'd0;
                        state_d     = WR_LOW;
                    end
                end
            end
            WR_LOW: begin
                if (cnt_q == WR_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = WR_REC;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WR_REC: begin
                if (init_mode_q && step_q != STEP_LAST) begin
                    // Chain straight into the next init byte; all follow-on bytes use A0=1.
                    step_d  = next_step(step_q);
                    a0_d    = 1'b1;
                    data_d  = step_byte(next_step(step_q));
                    state_d = WR_LOW;
                end else begin
                    if (init_mode_q) init_done_d = 1'b1;
                    init_mode_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            ACK1: begin
                if (cnt_q == ACK_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = ACK_GAP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACK_GAP: begin
                state_d = ACK2;
            end
            ACK2: begin
                if (cnt_q == ACK_LAST) begin
                    // The PIC drives the vector during the second pulse.
                    vector_d = data_in;
                    cnt_d    = 8'd0;
                    state_d  = ACK_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ACK_DONE: begin
                state_d = HOLDOFF;
            end
            HOLDOFF: begin
                // INT is still high from the serviced request for a cycle; ignore it.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cs_n         = (state_q != WR_LOW);
    assign wr_n         = (state_q != WR_LOW);
    assign data_oe      = (state_q == WR_LOW);
    assign rd_n         = 1'b1;
    assign int_ack      = (state_q == ACK1) || (state_q == ACK2);
    assign vector_valid = (state_q == ACK_DONE);
    assign a0           = a0_q;
    assign data_out     = data_q;
    assign vector       = vector_q;
    assign init_done    = init_done_q;

endmodule

// File: tb/tb_pic_host_initiator.sv
// Directed testbench for pic_host_initiator: init sequence (default and a
// cascade/no-ICW4 configuration), command writes, INT acknowledge, holdoff,
// arbitration and reset during a write.
module tb_pic_host_initiator;

    logic       clk = 1'b0;
    logic       reset, start_init, cmd_valid, cmd_a0, INT;
    logic [7:0] cmd_data, data_in;

    logic       init_done, cmd_ready, int_ack, cs_n, wr_n, rd_n, a0, data_oe, vector_valid;
    logic [7:0] data_out, vector;

    logic       u1_init_done, u1_cmd_ready, u1_int_ack, u1_cs_n, u1_wr_n, u1_rd_n;
    logic       u1_a0, u1_data_oe, u1_vector_valid;
    logic [7:0] u1_data_out, u1_vector;

    logic [7:0] pic_vec;
    int         pulse_no;
    logic       prev_ack;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] e0_d [4];
    logic [7:0] e1_d [4];
    logic       e_a0 [4];

    always #5 clk = ~clk;

    pic_host_initiator dut (
        .clk(clk), .reset(reset), .start_init(start_init), .init_done(init_done),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .INT(INT), .int_ack(int_ack), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in),
        .vector(vector), .vector_valid(vector_valid)
    );

    pic_host_initiator #(.ICW1(8'h10)) dut1 (
        .clk(clk), .reset(reset), .start_init(start_init), .init_done(u1_init_done),
        .cmd_valid(cmd_valid), .cmd_ready(u1_cmd_ready), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .INT(INT), .int_ack(u1_int_ack), .cs_n(u1_cs_n), .wr_n(u1_wr_n), .rd_n(u1_rd_n),
        .a0(u1_a0), .data_out(u1_data_out), .data_oe(u1_data_oe), .data_in(data_in),
        .vector(u1_vector), .vector_valid(u1_vector_valid)
    );

    // PIC model: drives the vector only while the second int_ack pulse is high.
    assign data_in = (int_ack && pulse_no == 2) ? pic_vec : 8'h00;

    always @(negedge clk) begin
        prev_ack <= int_ack;
        if (reset || vector_valid) pulse_no <= 0;
        else if (int_ack && !prev_ack) pulse_no <= pulse_no + 1;
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %02h expected %02h", tag, $time, got, exp);
        end
    endtask

    // Six cycles of an acknowledge starting the cycle after INT was sampled.
    task automatic ack_window(input logic [7:0] vexp, input bit pulse_init);
        logic [7:0] exp_ack [6];
        exp_ack = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("ack_int_ack", 8'(int_ack), exp_ack[c-1]);
            check("ack_vector_valid", 8'(vector_valid), 8'(c == 6));
            check("ack_rd_n", 8'(rd_n), 8'h01);
            check("ack_cs_n", 8'(cs_n), 8'h01);
            check("ack_data_oe", 8'(data_oe), 8'h00);
            check("ack_cmd_ready", 8'(cmd_ready), 8'h00);
            if (c == 6) check("ack_vector", vector, vexp);
            if (pulse_init && c == 1) start_init = 1'b1;
            if (c == 2) start_init = 1'b0;
        end
    endtask

    initial begin
        e0_d = '{8'h13, 8'h20, 8'h01, 8'hFF};
        e1_d = '{8'h10, 8'h20, 8'h00, 8'hFF};
        e_a0 = '{1'b0, 1'b1, 1'b1, 1'b1};
        reset = 1'b1; start_init = 1'b0; INT = 1'b0; pic_vec = 8'h00;
        cmd_valid = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h20;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cs_n", 8'(cs_n), 8'h01);
        check("rst_wr_n", 8'(wr_n), 8'h01);
        check("rst_rd_n", 8'(rd_n), 8'h01);
        check("rst_int_ack", 8'(int_ack), 8'h00);
        check("rst_a0", 8'(a0), 8'h00);
        check("rst_data_out", data_out, 8'h00);
        check("rst_data_oe", 8'(data_oe), 8'h00);
        check("rst_cmd_ready", 8'(cmd_ready), 8'h00);
        check("rst_init_done", 8'(init_done), 8'h00);
        check("rst_vector", vector, 8'h00);
        check("rst_vector_valid", 8'(vector_valid), 8'h00);
        @(posedge clk); #1 reset = 1'b0;

        // cmd_valid held before init: never accepted
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("preinit_cmd_ready", 8'(cmd_ready), 8'h00);
            check("preinit_wr_n", 8'(wr_n), 8'h01);
        end

        // Init sequence on both configurations
        @(posedge clk); #1 start_init = 1'b1;
        @(posedge clk); #1 start_init = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            bit lo;
            int slot;
            @(negedge clk);
            lo   = (c <= 12) && (((c - 1) % 3) < 2);
            slot = (c - 1) / 3;
            check("init_wr_n", 8'(wr_n), 8'(!lo));
            check("init1_wr_n", 8'(u1_wr_n), 8'(!lo));
            check("init_done", 8'(init_done), 8'(c == 13));
            check("init1_done", 8'(u1_init_done), 8'(c == 13));
            check("init_cmd_ready", 8'(cmd_ready), 8'(c == 13));
            if (lo) begin
                check("init_data", data_out, e0_d[slot]);
                check("init_a0", 8'(a0), 8'(e_a0[slot]));
                check("init_cs_n", 8'(cs_n), 8'h00);
                check("init_data_oe", 8'(data_oe), 8'h01);
                check("init1_data", u1_data_out, e1_d[slot]);
                check("init1_a0", 8'(u1_a0), 8'(e_a0[slot]));
            end
        end

        // Held command is accepted at the first ready cycle and written once
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int c = 14; c <= 20; c++) begin
            @(negedge clk);
            check("cmd_wr_n", 8'(wr_n), 8'((c != 14) && (c != 15)));
            if (c == 14) begin
                check("cmd_ready_fall", 8'(cmd_ready), 8'h00);
                check("cmd_a0", 8'(a0), 8'h00);
                check("cmd_data", data_out, 8'h20);
            end
        end

        // INT ack, INT dropped during ACK1, start_init while busy ignored
        @(posedge clk); #1 INT = 1'b1; pic_vec = 8'h23;
        @(posedge clk); #1 INT = 1'b0;
        ack_window(8'h23, 1'b1);
        for (int c = 7; c <= 8; c++) begin
            @(negedge clk);
            check("ack1_tail_int_ack", 8'(int_ack), 8'h00);
            check("ack1_tail_wr_n", 8'(wr_n), 8'h01);
        end
        check("busy_init_ignored", 8'(init_done), 8'h01);
        check("ack1_vector_hold", vector, 8'h23);

        // INT and cmd_valid together: ack first, command after HOLDOFF
        @(posedge clk); #1 INT = 1'b1; cmd_valid = 1'b1; cmd_a0 = 1'b0; cmd_data = 8'h20;
        pic_vec = 8'hA7;
        @(posedge clk); #1 INT = 1'b0;
        ack_window(8'hA7, 1'b0);
        @(negedge clk);
        check("arb_holdoff_ready", 8'(cmd_ready), 8'h00);
        @(negedge clk);
        check("arb_idle_ready", 8'(cmd_ready), 8'h01);
        check("arb_idle_wr_n", 8'(wr_n), 8'h01);
        @(posedge clk); #1 cmd_valid = 1'b0;
        for (int c = 9; c <= 13; c++) begin
            @(negedge clk);
            check("arb_wr_n", 8'(wr_n), 8'((c != 9) && (c != 10)));
            if (c == 9) begin
                check("arb_a0", 8'(a0), 8'h00);
                check("arb_data", data_out, 8'h20);
            end
        end

        // INT held high: next ack no earlier than 2 cycles after vector_valid
        @(posedge clk); #1 INT = 1'b1; pic_vec = 8'h5C;
        @(posedge clk);
        ack_window(8'h5C, 1'b0);
        for (int c = 7; c <= 16; c++) begin
            @(negedge clk);
            check("hold_int_ack", 8'(int_ack),
                  8'((c == 9) || (c == 10) || (c == 12) || (c == 13)));
            check("hold_vector_valid", 8'(vector_valid), 8'(c == 14));
            if (c == 9) INT = 1'b0;
            if (c == 14) check("hold_vector", vector, 8'h5C);
        end

        // Reset during the second init write
        @(posedge clk); #1 start_init = 1'b1;
        @(posedge clk); #1 start_init = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (c == 1) check("reinit_done_cleared", 8'(init_done), 8'h00);
            if (c == 4) begin
                check("mid_wr_n", 8'(wr_n), 8'h00);
                check("mid_data", data_out, 8'h20);
                reset = 1'b1;
            end
            if (c == 5) begin
                check("rstw_wr_n", 8'(wr_n), 8'h01);
                check("rstw_cs_n", 8'(cs_n), 8'h01);
                check("rstw_data_oe", 8'(data_oe), 8'h00);
                check("rstw_init_done", 8'(init_done), 8'h00);
                check("rstw_a0", 8'(a0), 8'h00);
                check("rstw_data_out", data_out, 8'h00);
                reset = 1'b0;
            end
            if (c >= 6 && c <= 8) begin
                check("rstw_no_resume_wr_n", 8'(wr_n), 8'h01);
                check("rstw_no_ack", 8'(int_ack), 8'h00);
            end
            if (c == 8) start_init = 1'b1;
            if (c == 9) begin
                start_init = 1'b0;
                check("rstw_restart_wr_n", 8'(wr_n), 8'h00);
                check("rstw_restart_data", data_out, 8'h13);
                check("rstw_restart_a0", 8'(a0), 8'h00);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
